// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion: one 32-bit word per cycle into a round-key store, keys read by index.
// Define AES_KEY_ZEROIZE_EN to add the zeroize input that wipes the key material.
module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                start_doing,
  input  logic [KEY_BITS-1:0] rx_key,
  input  logic [3:0]          cur_round,
  output logic [127:0]        cur_key,
  output logic                key_valid,
  output logic                busy,
  output logic                done
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] NW_W     = 6'(NW);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [3:0] NR_W     = 4'(NR);
  localparam logic [2:0] POS_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = p ^ (b[k] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box = multiplicative inverse (a^254, which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t              state_r, state_next_s;
  logic [31:0]         w_r [NW];
  logic [KEY_BITS-1:0] key_r;
  logic [5:0]          idx_r;
  logic [2:0]          pos_r;
  logic [7:0]          rcon_r;
  logic                zero_s, start_ok_s, rd_ok_s;
  logic [31:0]         prev_s, temp_s, new_word_s;
  logic [5:0]          limit_s, rd_base_s;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_s = zeroize;
`else
  assign zero_s = 1'b0;
`endif

  assign start_ok_s = start_doing && !zero_s && (state_r == IDLE || state_r == DONE);

  // Next-state logic; zeroize overrides everything.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start_ok_s ? LOAD : IDLE;
      LOAD:    state_next_s = EXPAND;
      EXPAND:  state_next_s = (idx_r == LAST_W) ? DONE : EXPAND;
      DONE:    state_next_s = start_ok_s ? LOAD : DONE;
      default: state_next_s = IDLE;
    endcase
    if (zero_s) begin
      state_next_s = IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Word rule for w[idx_r]; pos_r tracks idx_r mod NK.
  always_comb begin
    prev_s = w_r[idx_r - 6'd1];
    temp_s = prev_s;
    if (pos_r == 3'd0) begin
      temp_s = sub_word({prev_s[23:0], prev_s[31:24]}) ^ {rcon_r, 24'h000000};
    end else if (NK == 8 && pos_r == 3'd4) begin
      temp_s = sub_word(prev_s);
    end else begin
      temp_s = prev_s;
    end
    new_word_s = w_r[idx_r - NK_W] ^ temp_s;
  end

  // Read address and count of words written during the current expansion.
  always_comb begin
    rd_ok_s = (cur_round <= NR_W);
    if (rd_ok_s) begin
      rd_base_s = {cur_round, 2'b00};
    end else begin
      rd_base_s = 6'd0;
    end
    case (state_r)
      EXPAND:  limit_s = idx_r;
      DONE:    limit_s = NW_W;
      default: limit_s = 6'd0;
    endcase
  end

  // State register and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == LOAD) || (state_next_s == EXPAND);
      done    <= (state_next_s == DONE);
    end
  end

  // Cipher key latch, word index, position within key and Rcon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || zero_s) begin
      key_r  <= '0;
      idx_r  <= NK_W;
      pos_r  <= 3'd0;
      rcon_r <= 8'h01;
    end else begin
      if (start_ok_s) begin
        key_r <= rx_key;
      end
      case (state_r)
        LOAD: begin
          idx_r  <= NK_W;
          pos_r  <= 3'd0;
          rcon_r <= 8'h01;
        end
        EXPAND: begin
          idx_r  <= idx_r + 6'd1;
          pos_r  <= (pos_r == POS_LAST) ? 3'd0 : pos_r + 3'd1;
          rcon_r <= (pos_r == 3'd0) ? xtime(rcon_r) : rcon_r;
        end
        default: ;
      endcase
    end
  end

  // Round-key word store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || zero_s) begin
      for (int k = 0; k < NW; k++) w_r[k] <= 32'h0;
    end else if (state_r == LOAD) begin
      for (int k = 0; k < NK; k++) w_r[k] <= key_r[KEY_BITS-1-32*k -: 32];
    end else if (state_r == EXPAND) begin
      w_r[idx_r] <= new_word_s;
    end
  end

  // Registered round-key read; an accepted start invalidates the output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || zero_s) begin
      cur_key   <= 128'h0;
      key_valid <= 1'b0;
    end else if (!rd_ok_s) begin
      cur_key   <= 128'h0;
      key_valid <= 1'b0;
    end else begin
      cur_key   <= {w_r[rd_base_s], w_r[rd_base_s + 6'd1], w_r[rd_base_s + 6'd2], w_r[rd_base_s + 6'd3]};
      key_valid <= !start_ok_s && ((rd_base_s + 6'd3) < limit_s);
    end
  end
endmodule
